// File: rtl/acc_ctrl_pkg.sv
// Shared types for the accumulator op sequencer: FSM states, opcode encoding
// and the default-width queue entry layout.
package acc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ISSUE,
      S_WAIT,
      S_DONE,
      S_HALT
   } acc_seq_state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int ACC_W = 8;

   typedef struct packed {
      logic             op;
      logic [ACC_W-1:0] data;
   } acc_op_entry_t;

endpackage

// File: rtl/acc_op_fifo.sv
// Synchronous FIFO holding queued {op, operand} entries, with flush.
// The head entry is presented combinationally on rdata.
module acc_op_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/acc_op_sequencer.sv
// Runs a queued add/sub program through an external accumulator: clears it,
// issues one op every other cycle, and watches the returned overflow flag.
module acc_op_sequencer
   import acc_ctrl_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 4,
   parameter bit STOP_ON_OVF = 1'b1,
   localparam int CW         = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             push_op,
   input  logic             start,
   input  logic             abort,
   input  logic             acc_overflow,
   output logic             acc_clr,
   output logic             acc_en,
   output logic             acc_add_sub,
   output logic [WIDTH-1:0] acc_a,
   output logic             busy,
   output logic             done,
   output logic             halted,
   output logic             ovf_seen,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   acc_seq_state_t state;
   acc_seq_state_t next_state;
   logic [WIDTH:0] head;
   logic           idle_like;
   logic           fifo_push;

   assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_HALT);
   assign busy      = (state == S_CLEAR) || (state == S_ISSUE) || (state == S_WAIT);
   assign done      = (state == S_DONE);
   assign halted    = (state == S_HALT);
   // abort suppresses any pulse in the cycle it is asserted
   assign acc_clr   = (state == S_CLEAR) && !abort;
   assign acc_en    = (state == S_ISSUE) && !abort;
   assign fifo_push = push && idle_like && !abort;

   acc_op_fifo #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (abort),
      .push  (fifo_push),
      .pop   (acc_en),
      .wdata ({push_op, push_data}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE, S_DONE, S_HALT: begin
            // empty check uses the pre-push count, so a lone push+start only enqueues
            if (start && !empty)     next_state = S_CLEAR;
            else if (push && !full)  next_state = S_IDLE;
         end
         S_CLEAR: next_state = S_ISSUE;
         S_ISSUE: next_state = S_WAIT;
         S_WAIT: begin
            if (acc_overflow && STOP_ON_OVF) next_state = S_HALT;
            else if (empty)                  next_state = S_DONE;
            else                             next_state = S_ISSUE;
         end
         default: next_state = S_IDLE;
      endcase
      if (abort) next_state = S_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         acc_a       <= '0;
         acc_add_sub <= OP_ADD;
         ovf_seen    <= 1'b0;
      end else begin
         state <= next_state;
         if (abort) begin
            acc_a       <= '0;
            acc_add_sub <= OP_ADD;
            ovf_seen    <= 1'b0;
         end else begin
            // operand register loads the head as ISSUE is entered and holds otherwise
            if (next_state == S_ISSUE) begin
               acc_a       <= head[WIDTH-1:0];
               acc_add_sub <= head[WIDTH];
            end
            if (idle_like && next_state != state) ovf_seen <= 1'b0;
            else if (state == S_WAIT && acc_overflow) ovf_seen <= 1'b1;
         end
      end
   end

endmodule
